// File: rtl/sb_regfile.sv
// sb_regfile: register file with a per-register pending (scoreboard) bit.
// Register 0 is hard-wired to zero and can never be reserved. Two combinational
// read ports (S and A) forward same-cycle write data, and an illegal reserve of
// an already-pending register produces a registered one-cycle error pulse.
module sb_regfile #(
  parameter int WIDTH  = 32,
  parameter int DEPTH  = 32,
  parameter int ADDR_W = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [WIDTH-1:0]  sbus_in,
  input  logic              write_en,
  input  logic [ADDR_W-1:0] write_select,
  input  logic [ADDR_W-1:0] sbus_select,
  input  logic [ADDR_W-1:0] alu_select,
  input  logic              rsv_en,
  input  logic [ADDR_W-1:0] rsv_select,
  output logic [WIDTH-1:0]  sbus_out,
  output logic [WIDTH-1:0]  alu_out,
  output logic              sbus_valid,
  output logic              alu_valid,
  output logic [DEPTH-1:0]  busy_vec,
  output logic              rsv_err
);

  logic [WIDTH-1:0] regs [DEPTH];
  logic [DEPTH-1:0] busy;
  logic             rsv_err_q;
  logic             wr_hit;
  logic             rsv_hit;
  logic             rsv_conflict;

  // Address 0 is never a legal target for either a write or a reserve.
  assign wr_hit  = write_en && (write_select != '0);
  assign rsv_hit = rsv_en && (rsv_select != '0);

  // A reserve is illegal only if the register is already pending and the same
  // edge does not also retire it with a write.
  assign rsv_conflict = rsv_hit && busy[rsv_select] &&
                        !(wr_hit && (write_select == rsv_select));

  // Data storage: cleared on reset, loaded on a legal write.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        regs[i] <= '0;
      end
    end else if (wr_hit) begin
      regs[write_select] <= sbus_in;
    end
  end

  // Pending bits: a write clears, a reserve sets; reserve wins on a collision.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy <= '0;
    end else begin
      busy[0] <= 1'b0;
      for (int i = 1; i < DEPTH; i++) begin
        if (rsv_hit && (rsv_select == ADDR_W'(i))) begin
          busy[i] <= 1'b1;
        end else if (wr_hit && (write_select == ADDR_W'(i))) begin
          busy[i] <= 1'b0;
        end
      end
    end
  end

  // Error pulse: high for exactly the cycle after an illegal reserve.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rsv_err_q <= 1'b0;
    end else begin
      rsv_err_q <= rsv_conflict;
    end
  end

  // Port S read with same-cycle write forwarding (suppressed while in reset).
  always_comb begin
    sbus_out   = '0;
    sbus_valid = 1'b1;
    if (rst_n && wr_hit && (write_select == sbus_select)) begin
      sbus_out = sbus_in;
    end else if (sbus_select != '0) begin
      sbus_out   = regs[sbus_select];
      sbus_valid = ~busy[sbus_select];
    end
  end

  // Port A read with same-cycle write forwarding (suppressed while in reset).
  always_comb begin
    alu_out   = '0;
    alu_valid = 1'b1;
    if (rst_n && wr_hit && (write_select == alu_select)) begin
      alu_out = sbus_in;
    end else if (alu_select != '0) begin
      alu_out   = regs[alu_select];
      alu_valid = ~busy[alu_select];
    end
  end

  assign busy_vec = busy;
  assign rsv_err  = rsv_err_q;

endmodule

// File: tb/tb_sb_regfile.sv
// tb_sb_regfile: self-checking bench for sb_regfile. Directed table vectors
// cover forwarding, the scoreboard and reserve conflicts; randomized traffic is
// compared against an array-based reference model; async reset is exercised
// between clock edges. WIDTH/DEPTH are bench parameters so the same bench
// covers the 8/4 and 64/64 configurations.
module tb_sb_regfile;
  parameter int WIDTH = 32;
  parameter int DEPTH = 32;
  localparam int ADDR_W = $clog2(DEPTH);

  localparam int A_B = (DEPTH > 5) ? 5 : 1;
  localparam int A_S = (DEPTH > 7) ? 7 : DEPTH - 1;
  localparam int A_C = (DEPTH > 3) ? 3 : 1;
  localparam int A_R = (DEPTH > 4) ? 4 : 1;

  localparam logic [WIDTH-1:0] D_BYP = WIDTH'(64'hA5A5A5A5);
  localparam logic [WIDTH-1:0] D_SB  = WIDTH'(64'h12345678);
  localparam logic [WIDTH-1:0] D_CF  = WIDTH'(64'h0F1E2D3C);
  localparam logic [WIDTH-1:0] D_DB  = WIDTH'(64'hDEADBEEF);
  localparam logic [WIDTH-1:0] ZERO  = '0;

  logic              clk;
  logic              rst_n;
  logic [WIDTH-1:0]  sbus_in;
  logic              write_en;
  logic [ADDR_W-1:0] write_select;
  logic [ADDR_W-1:0] sbus_select;
  logic [ADDR_W-1:0] alu_select;
  logic              rsv_en;
  logic [ADDR_W-1:0] rsv_select;
  logic [WIDTH-1:0]  sbus_out;
  logic [WIDTH-1:0]  alu_out;
  logic              sbus_valid;
  logic              alu_valid;
  logic [DEPTH-1:0]  busy_vec;
  logic              rsv_err;

  int checks = 0;
  int errors = 0;

  // Reference model state
  logic [WIDTH-1:0] m_mem [DEPTH];
  bit               m_busy [DEPTH];
  bit               m_err;

  typedef struct {
    logic              we;
    logic [ADDR_W-1:0] ws;
    logic [WIDTH-1:0]  din;
    logic [ADDR_W-1:0] ss;
    logic [ADDR_W-1:0] as;
    logic              re;
    logic [ADDR_W-1:0] rs;
    logic [WIDTH-1:0]  exp_sout;
    logic              exp_sv;
    logic [WIDTH-1:0]  exp_aout;
    logic              exp_av;
    logic [ADDR_W-1:0] chk;
    logic              exp_busy;
    logic              exp_err;
  } vec_t;

  vec_t vecs [15];

  sb_regfile #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .sbus_in      (sbus_in),
    .write_en     (write_en),
    .write_select (write_select),
    .sbus_select  (sbus_select),
    .alu_select   (alu_select),
    .rsv_en       (rsv_en),
    .rsv_select   (rsv_select),
    .sbus_out     (sbus_out),
    .alu_out      (alu_out),
    .sbus_valid   (sbus_valid),
    .alu_valid    (alu_valid),
    .busy_vec     (busy_vec),
    .rsv_err      (rsv_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic vec_t mk(input logic we, input int ws, input logic [WIDTH-1:0] din,
                              input int ss, input int as, input logic re, input int rs,
                              input logic [WIDTH-1:0] esout, input logic esv,
                              input logic [WIDTH-1:0] eaout, input logic eav,
                              input int chk, input logic ebusy, input logic eerr);
    vec_t v;
    v.we = we; v.ws = ADDR_W'(ws); v.din = din;
    v.ss = ADDR_W'(ss); v.as = ADDR_W'(as);
    v.re = re; v.rs = ADDR_W'(rs);
    v.exp_sout = esout; v.exp_sv = esv; v.exp_aout = eaout; v.exp_av = eav;
    v.chk = ADDR_W'(chk); v.exp_busy = ebusy; v.exp_err = eerr;
    return v;
  endfunction

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic applyStimulus(input logic we, input int ws, input logic [WIDTH-1:0] din,
                               input int ss, input int as, input logic re, input int rs);
    write_en     = we;
    write_select = ADDR_W'(ws);
    sbus_in      = din;
    sbus_select  = ADDR_W'(ss);
    alu_select   = ADDR_W'(as);
    rsv_en       = re;
    rsv_select   = ADDR_W'(rs);
  endtask

  task automatic model_reset();
    for (int i = 0; i < DEPTH; i++) begin
      m_mem[i]  = '0;
      m_busy[i] = 1'b0;
    end
    m_err = 1'b0;
  endtask

  // Expected {valid, data} for a read address given current inputs and model state.
  function automatic logic [WIDTH:0] model_read(input logic [ADDR_W-1:0] sel);
    if (!rst_n) return {1'b1, ZERO};
    if (sel == '0) return {1'b1, ZERO};
    if (write_en && write_select == sel) return {1'b1, sbus_in};
    return {~m_busy[sel], m_mem[sel]};
  endfunction

  function automatic logic [DEPTH-1:0] model_busy_vec();
    logic [DEPTH-1:0] v;
    for (int i = 0; i < DEPTH; i++) v[i] = m_busy[i];
    return v;
  endfunction

  // Apply the rising-edge rules to the model using the inputs held at the edge.
  task automatic model_edge();
    bit nerr;
    if (!rst_n) return;
    nerr = rsv_en && (rsv_select != '0) && m_busy[rsv_select] &&
           !(write_en && write_select == rsv_select);
    if (write_en && write_select != '0) begin
      m_mem[write_select]  = sbus_in;
      m_busy[write_select] = 1'b0;
    end
    if (rsv_en && rsv_select != '0) m_busy[rsv_select] = 1'b1;
    m_err = nerr;
  endtask

  task automatic pre_checks(input string tag);
    logic [WIDTH:0] es;
    logic [WIDTH:0] ea;
    es = model_read(sbus_select);
    ea = model_read(alu_select);
    checkOutput({tag, " sbus_out"},   64'(sbus_out),   64'(es[WIDTH-1:0]));
    checkOutput({tag, " sbus_valid"}, 64'(sbus_valid), 64'(es[WIDTH]));
    checkOutput({tag, " alu_out"},    64'(alu_out),    64'(ea[WIDTH-1:0]));
    checkOutput({tag, " alu_valid"},  64'(alu_valid),  64'(ea[WIDTH]));
  endtask

  task automatic post_checks(input string tag);
    checkOutput({tag, " busy_vec"}, 64'(busy_vec), 64'(model_busy_vec()));
    checkOutput({tag, " rsv_err"},  64'(rsv_err),  64'(m_err));
  endtask

  // One clock cycle: inputs already applied at posedge+1.
  task automatic cycle(input string tag);
    #2;
    pre_checks(tag);
    @(posedge clk);
    #1;
    model_edge();
    post_checks(tag);
  endtask

  initial begin
    logic [WIDTH-1:0] rdata;
    int ws, ss, as, rs;

    vecs[0]  = mk(1, A_B, D_BYP, A_B, A_B, 0, 0,   D_BYP, 1, D_BYP, 1, A_B, 0, 0);
    vecs[1]  = mk(0, 0,   ZERO,  A_B, A_B, 0, 0,   D_BYP, 1, D_BYP, 1, A_B, 0, 0);
    vecs[2]  = mk(1, A_S, ZERO,  0,   0,   0, 0,   ZERO,  1, ZERO,  1, A_S, 0, 0);
    vecs[3]  = mk(0, 0,   ZERO,  A_S, A_S, 1, A_S, ZERO,  1, ZERO,  1, A_S, 1, 0);
    vecs[4]  = mk(0, 0,   ZERO,  A_S, A_S, 0, 0,   ZERO,  0, ZERO,  0, A_S, 1, 0);
    vecs[5]  = mk(1, A_S, D_SB,  A_S, A_S, 0, 0,   D_SB,  1, D_SB,  1, A_S, 0, 0);
    vecs[6]  = mk(0, 0,   ZERO,  A_S, A_S, 0, 0,   D_SB,  1, D_SB,  1, A_S, 0, 0);
    vecs[7]  = mk(0, 0,   ZERO,  0,   0,   1, A_C, ZERO,  1, ZERO,  1, A_C, 1, 0);
    vecs[8]  = mk(0, 0,   ZERO,  0,   0,   1, A_C, ZERO,  1, ZERO,  1, A_C, 1, 1);
    vecs[9]  = mk(0, 0,   ZERO,  0,   0,   0, 0,   ZERO,  1, ZERO,  1, A_C, 1, 0);
    vecs[10] = mk(1, A_C, D_CF,  A_C, A_C, 1, A_C, D_CF,  1, D_CF,  1, A_C, 1, 0);
    vecs[11] = mk(0, 0,   ZERO,  A_C, A_C, 0, 0,   D_CF,  0, D_CF,  0, A_C, 1, 0);
    vecs[12] = mk(1, A_C, D_CF,  0,   A_C, 0, 0,   ZERO,  1, D_CF,  1, A_C, 0, 0);
    vecs[13] = mk(1, 0,   D_DB,  0,   0,   0, 0,   ZERO,  1, ZERO,  1, 0,   0, 0);
    vecs[14] = mk(0, 0,   ZERO,  0,   0,   1, 0,   ZERO,  1, ZERO,  1, 0,   0, 0);

    // Reset state, with a write attempt whose forwarding must be suppressed
    model_reset();
    rst_n = 1'b0;
    applyStimulus(0, 0, ZERO, 0, 0, 0, 0);
    #3;
    checkOutput("reset busy_vec", 64'(busy_vec), 64'd0);
    checkOutput("reset rsv_err",  64'(rsv_err),  64'd0);
    applyStimulus(1, 1, D_BYP, 1, 1, 1, 1);
    #1;
    pre_checks("reset bypass-suppressed");
    checkOutput("reset sbus_out direct", 64'(sbus_out), 64'd0);
    @(posedge clk);
    #1;
    post_checks("reset write-ignored");
    #2;
    rst_n = 1'b1;
    applyStimulus(0, 0, ZERO, 1, 1, 0, 0);
    @(posedge clk);
    #1;
    pre_checks("after release");

    // Directed vectors
    for (int i = 0; i < 15; i++) begin
      applyStimulus(vecs[i].we, int'(vecs[i].ws), vecs[i].din, int'(vecs[i].ss),
                    int'(vecs[i].as), vecs[i].re, int'(vecs[i].rs));
      #2;
      checkOutput($sformatf("vec%0d sbus_out", i),   64'(sbus_out),   64'(vecs[i].exp_sout));
      checkOutput($sformatf("vec%0d sbus_valid", i), 64'(sbus_valid), 64'(vecs[i].exp_sv));
      checkOutput($sformatf("vec%0d alu_out", i),    64'(alu_out),    64'(vecs[i].exp_aout));
      checkOutput($sformatf("vec%0d alu_valid", i),  64'(alu_valid),  64'(vecs[i].exp_av));
      @(posedge clk);
      #1;
      model_edge();
      checkOutput($sformatf("vec%0d busy bit", i), 64'(busy_vec[vecs[i].chk]), 64'(vecs[i].exp_busy));
      checkOutput($sformatf("vec%0d rsv_err", i),  64'(rsv_err),                64'(vecs[i].exp_err));
      post_checks($sformatf("vec%0d model", i));
    end

    // Write/readback of every register through both ports
    for (int a = 1; a < DEPTH; a++) begin
      rdata = WIDTH'({$urandom(), $urandom()});
      applyStimulus(1, a, rdata, 0, 0, 0, 0);
      cycle($sformatf("wr%0d", a));
    end
    for (int a = 1; a < DEPTH; a++) begin
      applyStimulus(0, 0, ZERO, a, 0, 0, 0);
      cycle($sformatf("rd-s%0d", a));
      applyStimulus(0, 0, ZERO, 0, a, 0, 0);
      cycle($sformatf("rd-a%0d", a));
    end

    // Randomized traffic against the model
    for (int n = 0; n < 400; n++) begin
      ws = $urandom_range(0, DEPTH - 1);
      rs = ($urandom_range(0, 2) == 0) ? ws : $urandom_range(0, DEPTH - 1);
      ss = ($urandom_range(0, 3) == 0) ? ws : $urandom_range(0, DEPTH - 1);
      as = ($urandom_range(0, 3) == 0) ? ss : $urandom_range(0, DEPTH - 1);
      applyStimulus(1'($urandom_range(0, 1)), ws, WIDTH'({$urandom(), $urandom()}),
                    ss, as, 1'($urandom_range(0, 1)), rs);
      cycle($sformatf("rnd%0d", n));
    end

    // Async reset between edges with a pending register and an active error pulse
    applyStimulus(1, 1, D_SB, 0, 0, 0, 0);
    cycle("pre-reset write1");
    applyStimulus(0, 0, ZERO, 0, 0, 1, A_R);
    cycle("pre-reset rsv1");
    applyStimulus(0, 0, ZERO, 0, 0, 1, A_R);
    cycle("pre-reset rsv2");
    checkOutput("pre-reset rsv_err high", 64'(rsv_err), 64'd1);
    applyStimulus(0, 0, ZERO, 1, A_R, 0, 0);
    #2;
    rst_n = 1'b0;
    #1;
    model_reset();
    checkOutput("async sbus_out",   64'(sbus_out),   64'd0);
    checkOutput("async sbus_valid", 64'(sbus_valid), 64'd1);
    checkOutput("async alu_out",    64'(alu_out),    64'd0);
    checkOutput("async alu_valid",  64'(alu_valid),  64'd1);
    checkOutput("async busy_vec",   64'(busy_vec),   64'd0);
    checkOutput("async rsv_err",    64'(rsv_err),    64'd0);
    @(posedge clk);
    #3;
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Traffic after release: no stale pending state may survive
    for (int n = 0; n < 60; n++) begin
      ws = $urandom_range(0, DEPTH - 1);
      ss = $urandom_range(0, DEPTH - 1);
      applyStimulus(1'($urandom_range(0, 1)), ws, WIDTH'({$urandom(), $urandom()}),
                    ss, ss, 1'($urandom_range(0, 1)), $urandom_range(0, DEPTH - 1));
      cycle($sformatf("post%0d", n));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
